// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment bit order is gfedcba in bits 6..0, with the decimal point in bit 7.
package seg7_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned FONT_W = 7;
  localparam int unsigned SEG_W  = 8;

  localparam logic [FONT_W-1:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [FONT_W-1:0] font_lookup(input logic [NIB_W-1:0] nib);
    return FONT[nib];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment (gfedcba) decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0]  nibble,
  output logic [FONT_W-1:0] seg_c
);

  always_comb begin
    seg_c = font_lookup(nibble);
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-cathode seven-segment driver with per-frame input snapshot.
// Define SEG7_LZB_EN to build leading-zero blanking.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIV        = 1000,
  parameter int unsigned GAP        = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [NIB_W*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]       dp,
  input  logic [NUM_DIGITS-1:0]       blank,
  output logic [SEG_W-1:0]            seg,
  output logic [NUM_DIGITS-1:0]       dig_n,
  output logic                        frame_start
);

  localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned ON_LEN = DIV - GAP;

  state_e                             state_q, state_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [NUM_DIGITS-1:0][NIB_W-1:0]   val_snap_q, val_snap_d;
  logic [NUM_DIGITS-1:0]              dp_snap_q, dp_snap_d;
  logic [NUM_DIGITS-1:0]              blank_snap_q, blank_snap_d;
  logic [SEG_W-1:0]                   seg_q, seg_d;
  logic [NUM_DIGITS-1:0]              dig_n_q, dig_n_d;
  logic                               frame_start_q, frame_start_d;

  logic [NIB_W-1:0]                   cur_nib_c;
  logic [FONT_W-1:0]                  cur_font_c;
  logic                               lz_sup_c;

  // State, slot counter, digit index and snapshot registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      val_snap_q    <= '0;
      dp_snap_q     <= '0;
      blank_snap_q  <= '0;
      seg_q         <= '0;
      dig_n_q       <= '1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      val_snap_q    <= val_snap_d;
      dp_snap_q     <= dp_snap_d;
      blank_snap_q  <= blank_snap_d;
      seg_q         <= seg_d;
      dig_n_q       <= dig_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Next state; the snapshot is refreshed whenever slot 0 is (re)entered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    val_snap_d   = val_snap_q;
    dp_snap_d    = dp_snap_q;
    blank_snap_d = blank_snap_q;

    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == S_IDLE) begin
      state_d      = S_ON;
      cnt_d        = '0;
      idx_d        = '0;
      val_snap_d   = value;
      dp_snap_d    = dp;
      blank_snap_d = blank;
    end else if (cnt_q == CNT_W'(DIV - 1)) begin
      state_d = S_ON;
      cnt_d   = '0;
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        idx_d        = '0;
        val_snap_d   = value;
        dp_snap_d    = dp;
        blank_snap_d = blank;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = ((32'(cnt_q) + 32'd1) >= ON_LEN) ? S_GAP : S_ON;
    end
  end

  assign cur_nib_c = val_snap_d[idx_d];

  seg7_hex_decode u_hex_decode (
    .nibble (cur_nib_c),
    .seg_c  (cur_font_c)
  );

`ifdef SEG7_LZB_EN
  // Digit idx (>0) is a leading zero when it and every higher nibble are zero.
  always_comb begin
    lz_sup_c = (idx_d != '0);
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((IDX_W'(j) >= idx_d) && (val_snap_d[j] != '0)) begin
        lz_sup_c = 1'b0;
      end
    end
  end
`else
  assign lz_sup_c = 1'b0;
`endif

  // Outputs are computed from next-state values so they move on the same edge.
  always_comb begin
    seg_d         = '0;
    dig_n_d       = '1;
    frame_start_d = 1'b0;
    if (state_d == S_ON) begin
      frame_start_d = (idx_d == '0) && (cnt_d == '0);
      if (!blank_snap_d[idx_d]) begin
        dig_n_d        = ~(NUM_DIGITS'(1) << idx_d);
        seg_d[SEG_DP]  = dp_snap_d[idx_d];
        if (!lz_sup_c) begin
          seg_d[SEG_G:SEG_A] = cur_font_c;
        end else if (!dp_snap_d[idx_d]) begin
          dig_n_d = '1;
        end
      end
    end
  end

  assign seg         = seg_q;
  assign dig_n       = dig_n_q;
  assign frame_start = frame_start_q;

endmodule
